// File: rtl/qspim_sckgen_if.sv
// Bundle of run request, SCK configuration and generated timing strobes
// shared between the SCK generator and the controller that drives it.
interface qspim_sckgen_if #(
    parameter int PW   = 8,
    parameter int DLYW = 2
);
    logic            en;
    logic [PW-1:0]   cfg_sck_period;
    logic            cfg_cpol;
    logic            cfg_cpha;
    logic [DLYW-1:0] cfg_smpl_dly;

    logic            spi_clk;
    logic            spi_start;
    logic            spi_lead;
    logic            spi_trail;
    logic            spi_launch;
    logic            spi_sample;
    logic            spi_clk_idle;

    // Controller side: requests SCK and consumes the strobes.
    modport master (
        output en, cfg_sck_period, cfg_cpol, cfg_cpha, cfg_smpl_dly,
        input  spi_clk, spi_start, spi_lead, spi_trail,
               spi_launch, spi_sample, spi_clk_idle
    );

    // Generator side.
    modport slave (
        input  en, cfg_sck_period, cfg_cpol, cfg_cpha, cfg_smpl_dly,
        output spi_clk, spi_start, spi_lead, spi_trail,
               spi_launch, spi_sample, spi_clk_idle
    );
endinterface

// File: rtl/qspim_sckgen.sv
// QSPI master SCK generator: divides clk into a programmable SCK period,
// emits lead/trail/launch/sample strobes aligned with the SCK edges, and
// only starts or stops SCK on whole-period boundaries.
module qspim_sckgen #(
    parameter int PW   = 8,
    parameter int DLYW = 2
) (
    input  logic           clk,
    input  logic           rstn,
    qspim_sckgen_if.slave  bus
);
    localparam int DEPTH = (1 << DLYW) - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] cnt_reg, cnt_next;
    logic [PW-1:0] per_reg, per_next;
    logic [PW-1:0] per_eff;
    logic [PW-1:0] half;

    logic spi_clk_reg,    spi_clk_next;
    logic spi_start_reg,  spi_start_next;
    logic spi_lead_reg,   spi_lead_next;
    logic spi_trail_reg,  spi_trail_next;
    logic spi_launch_reg, spi_launch_next;
    logic spi_sample_reg, spi_sample_next;
    logic spi_idle_reg,   spi_idle_next;
    logic smpl_src_next;

    // taps[k] is the sample source delayed by k cycles relative to the
    // strobe outputs; taps[0] is the not-yet-registered source.
    logic [DEPTH:0] taps;

    // Periods below 2 cannot hold both edges, so clamp them.
    assign per_eff = (bus.cfg_sck_period < PW'(2)) ? PW'(2) : bus.cfg_sck_period;
    // Leading-edge position of the period currently running.
    assign half    = per_reg >> 1;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start on request, stop only at a trailing edge.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if ((cnt_reg != half) && (cnt_reg == per_reg) && !bus.en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath logic: counter, period latch and next strobe values.
    always_comb begin
        cnt_next       = cnt_reg;
        per_next       = per_reg;
        spi_clk_next   = spi_clk_reg;
        spi_start_next = 1'b0;
        spi_lead_next  = 1'b0;
        spi_trail_next = 1'b0;
        case (state_reg)
            IDLE: begin
                spi_clk_next = bus.cfg_cpol;
                cnt_next     = PW'(1);
                if (bus.en) begin
                    spi_start_next = 1'b1;
                    per_next       = per_eff;
                end
            end
            RUN: begin
                if (cnt_reg == half) begin
                    spi_clk_next  = ~bus.cfg_cpol;
                    spi_lead_next = 1'b1;
                    cnt_next      = cnt_reg + PW'(1);
                end else if (cnt_reg == per_reg) begin
                    // Period boundary: new period config takes effect here.
                    spi_clk_next   = bus.cfg_cpol;
                    spi_trail_next = 1'b1;
                    cnt_next       = PW'(1);
                    per_next       = per_eff;
                end else begin
                    cnt_next = cnt_reg + PW'(1);
                end
            end
            default: begin
                spi_clk_next = bus.cfg_cpol;
                cnt_next     = PW'(1);
            end
        endcase
        spi_idle_next   = (state_next == IDLE);
        spi_launch_next = bus.cfg_cpha ? spi_lead_next  : spi_trail_next;
        smpl_src_next   = bus.cfg_cpha ? spi_trail_next : spi_lead_next;
        spi_sample_next = taps[bus.cfg_smpl_dly];
    end

    // Registered counter, period latch and all outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg        <= PW'(1);
            per_reg        <= PW'(2);
            spi_clk_reg    <= 1'b0;
            spi_start_reg  <= 1'b0;
            spi_lead_reg   <= 1'b0;
            spi_trail_reg  <= 1'b0;
            spi_launch_reg <= 1'b0;
            spi_sample_reg <= 1'b0;
            spi_idle_reg   <= 1'b1;
        end else begin
            cnt_reg        <= cnt_next;
            per_reg        <= per_next;
            spi_clk_reg    <= spi_clk_next;
            spi_start_reg  <= spi_start_next;
            spi_lead_reg   <= spi_lead_next;
            spi_trail_reg  <= spi_trail_next;
            spi_launch_reg <= spi_launch_next;
            spi_sample_reg <= spi_sample_next;
            spi_idle_reg   <= spi_idle_next;
        end
    end

    assign taps[0] = smpl_src_next;

    // Sample-source delay line, one flop per stage, flushed by reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dly
        logic stage_reg;

        // Shift one stage per clk.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                stage_reg <= 1'b0;
            end else begin
                stage_reg <= taps[gi];
            end
        end

        assign taps[gi+1] = stage_reg;
    end

    assign bus.spi_clk      = spi_clk_reg;
    assign bus.spi_start    = spi_start_reg;
    assign bus.spi_lead     = spi_lead_reg;
    assign bus.spi_trail    = spi_trail_reg;
    assign bus.spi_launch   = spi_launch_reg;
    assign bus.spi_sample   = spi_sample_reg;
    assign bus.spi_clk_idle = spi_idle_reg;
endmodule

// File: tb/tb_qspim_sckgen.sv
// Testbench for qspim_sckgen: directed scenarios followed by randomized
// traffic, each clk edge checked against an edge-schedule reference model.
module tb_qspim_sckgen;
    localparam int PW   = 8;
    localparam int DLYW = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    always #5 clk = ~clk;

    qspim_sckgen_if #(.PW(PW), .DLYW(DLYW)) bus ();

    qspim_sckgen #(.PW(PW), .DLYW(DLYW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a running SCK is described by the cycle its current
    // period began and that period's length; edges fall at fixed offsets.
    bit       m_run    = 1'b0;
    int       m_cyc    = 0;
    int       m_pstart = 0;
    int       m_per    = 2;
    bit [3:0] m_hist   = '0;   // sample-source history, [0] = newest
    bit e_clk, e_start, e_lead, e_trail, e_launch, e_sample, e_idle;

    int obs_leads  = 0;
    int obs_trails = 0;

    function automatic int effp(int p);
        return (p < 2) ? 2 : p;
    endfunction

    task automatic chk(string tag, logic obs, logic exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, m_cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("spi_clk",      bus.spi_clk,      e_clk);
        chk("spi_start",    bus.spi_start,    e_start);
        chk("spi_lead",     bus.spi_lead,     e_lead);
        chk("spi_trail",    bus.spi_trail,    e_trail);
        chk("spi_launch",   bus.spi_launch,   e_launch);
        chk("spi_sample",   bus.spi_sample,   e_sample);
        chk("spi_clk_idle", bus.spi_clk_idle, e_idle);
        chk("lead_trail_excl", bus.spi_lead & bus.spi_trail, 1'b0);
    endtask

    // Advance one clk edge: predict from the inputs, then compare.
    task automatic tick();
        int off;
        bit src;
        e_start = 1'b0;
        e_lead  = 1'b0;
        e_trail = 1'b0;
        if (!m_run) begin
            e_clk  = bus.cfg_cpol;
            e_idle = 1'b1;
            if (bus.en) begin
                m_run    = 1'b1;
                m_pstart = m_cyc;
                m_per    = effp(int'(bus.cfg_sck_period));
                e_start  = 1'b1;
                e_idle   = 1'b0;
            end
        end else begin
            off    = m_cyc - m_pstart;
            e_idle = 1'b0;
            if (off == m_per) begin
                e_trail  = 1'b1;
                e_clk    = bus.cfg_cpol;
                m_pstart = m_cyc;
                m_per    = effp(int'(bus.cfg_sck_period));
                if (!bus.en) begin
                    m_run  = 1'b0;
                    e_idle = 1'b1;
                end
            end else begin
                e_lead = (off == m_per / 2);
                e_clk  = bus.cfg_cpol ^ (off >= m_per / 2);
            end
        end
        e_launch = bus.cfg_cpha ? e_lead  : e_trail;
        src      = bus.cfg_cpha ? e_trail : e_lead;
        m_hist   = {m_hist[2:0], src};
        e_sample = m_hist[bus.cfg_smpl_dly];
        m_cyc++;
        @(posedge clk);
        #1;
        $display("cyc=%0d en=%b per=%0d clk=%b start=%b lead=%b trail=%b launch=%b sample=%b idle=%b",
                 m_cyc, bus.en, bus.cfg_sck_period, bus.spi_clk, bus.spi_start, bus.spi_lead,
                 bus.spi_trail, bus.spi_launch, bus.spi_sample, bus.spi_clk_idle);
        if (bus.spi_lead)  obs_leads++;
        if (bus.spi_trail) obs_trails++;
        check_all();
    endtask

    // Asynchronous reset pulse, taken mid-cycle; outputs must clear at once.
    task automatic do_reset();
        rstn = 1'b0;
        #2;
        m_run    = 1'b0;
        m_hist   = '0;
        e_clk    = 1'b0;
        e_start  = 1'b0;
        e_lead   = 1'b0;
        e_trail  = 1'b0;
        e_launch = 1'b0;
        e_sample = 1'b0;
        e_idle   = 1'b1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rstn = 1'b1;
    endtask

    // Drop en and run until the generator reports idle (bounded).
    task automatic drain();
        int k;
        bus.en = 1'b0;
        k = 0;
        while (!(bus.spi_clk_idle && !m_run) && k < 40) begin
            tick();
            k++;
        end
        chk("drain_idle", bus.spi_clk_idle, 1'b1);
        tick();
    endtask

    // Run until a leading edge is observed (bounded).
    task automatic wait_lead(string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!bus.spi_lead && k < 20);
        chk(tag, bus.spi_lead, 1'b1);
    endtask

    initial begin
        bus.en             = 1'b0;
        bus.cfg_sck_period = 8'd4;
        bus.cfg_cpol       = 1'b1;
        bus.cfg_cpha       = 1'b0;
        bus.cfg_smpl_dly   = '0;

        #1;
        do_reset();
        // spi_clk must follow cpol=1 from the first edge after reset
        tick();
        tick();
        bus.cfg_cpol = 1'b0;
        tick();

        // cpol=0 cpha=0 P=4, exactly three periods
        obs_leads  = 0;
        obs_trails = 0;
        bus.en = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        bus.en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("three_leads",  1'(obs_leads == 3),  1'b1);
        chk("three_trails", 1'(obs_trails == 3), 1'b1);
        drain();

        // cpol=1 cpha=1 P=2
        bus.cfg_cpol       = 1'b1;
        bus.cfg_cpha       = 1'b1;
        bus.cfg_sck_period = 8'd2;
        bus.en             = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        drain();

        // odd period and clamped periods
        bus.cfg_cpol = 1'b0;
        bus.cfg_cpha = 1'b0;
        for (int p = 0; p < 6; p++) begin
            bus.cfg_sck_period = (p == 2) ? 8'd5 : 8'(p % 2);
            bus.en = 1'b1;
            for (int i = 0; i < 7; i++) tick();
            drain();
        end

        // period change 4 -> 6 mid-period
        bus.cfg_sck_period = 8'd4;
        bus.en = 1'b1;
        tick();
        tick();
        tick();
        bus.cfg_sck_period = 8'd6;
        for (int i = 0; i < 14; i++) tick();
        drain();

        // en dropped one cycle after the leading edge
        bus.cfg_sck_period = 8'd4;
        bus.en = 1'b1;
        wait_lead("drop_lead_seen");
        tick();
        bus.en = 1'b0;
        tick();
        chk("drop_trail",     bus.spi_trail,    1'b1);
        chk("drop_clk_cpol",  bus.spi_clk,      1'b0);
        chk("drop_idle_same", bus.spi_clk_idle, 1'b1);
        tick();
        tick();

        // sample delay of 2 cycles, cpha=0 (source = lead)
        bus.cfg_smpl_dly = 2'd2;
        bus.en = 1'b1;
        wait_lead("dly_lead_seen");
        tick();
        chk("dly_not_yet", bus.spi_sample, 1'b0);
        tick();
        chk("dly_two",     bus.spi_sample, 1'b1);
        drain();

        // reset during RUN flushes a pending delayed sample
        bus.cfg_smpl_dly = 2'd3;
        bus.en = 1'b1;
        wait_lead("rst_lead_seen");
        do_reset();
        bus.en = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            if (!m_run && $urandom_range(0, 3) == 0) begin
                bus.cfg_cpol = 1'($urandom_range(0, 1));
                bus.cfg_cpha = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) bus.cfg_sck_period = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) bus.cfg_smpl_dly   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) bus.en             = ~bus.en;
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/qspim_sckgen.md
QSPIM_SCKGEN -- requirements
Module: qspim_sckgen

Interface
REQ-001 Parameter: PW, default 8, width of the SCK period config and the internal counter (legal range 3..16).
REQ-002 Parameter: DLYW, default 2, width of the sample-delay config.
REQ-003 Port: clk, input, 1, system clock; the only clock.
REQ-004 Port: rstn, input, 1, reset; asynchronous, active-low.
REQ-005 Port: en, input, 1, request to run SCK.
REQ-006 Port: cfg_sck_period, input, PW, SCK period in clk cycles.
REQ-007 Port: cfg_cpol, input, 1, SCK idle level.
REQ-008 Port: cfg_cpha, input, 1, selects the data launch/sample edge.
REQ-009 Port: cfg_smpl_dly, input, DLYW, extra clk cycles of delay on the sample pulse.
REQ-010 Port: spi_clk, output, 1, serial clock.
REQ-011 Port: spi_start, output, 1, one-cycle pulse at the IDLE->RUN transition.
REQ-012 Port: spi_lead, output, 1, pulse that coincides with the leading SCK edge.
REQ-013 Port: spi_trail, output, 1, pulse that coincides with the trailing SCK edge.
REQ-014 Port: spi_launch, output, 1, transmit-data pulse.
REQ-015 Port: spi_sample, output, 1, receive-capture pulse (delayed by cfg_smpl_dly).
REQ-016 Port: spi_clk_idle, output, 1, high while the FSM is in IDLE.

Function
REQ-017 The block SHALL have FSM states IDLE and RUN; all outputs SHALL be registered.
REQ-018 Effective period P SHALL be max(cfg_sck_period,2); half-point H = P>>1.
REQ-019 P SHALL be latched into per_r on IDLE->RUN and at every trailing edge; cfg changes SHALL take effect only at a period boundary, with no counter restart and no glitch.
REQ-020 In IDLE: spi_clk = cfg_cpol, spi_clk_idle = 1, cnt = 1, all pulses = 0.
REQ-021 In IDLE with en = 1, the next edge SHALL move to RUN, drive spi_start = 1 for one cycle, set spi_clk_idle = 0, and set cnt = 1.
REQ-022 In RUN, on an edge with cnt == H: spi_clk <= ~cfg_cpol, spi_lead <= 1, cnt <= cnt+1.
REQ-023 In RUN, on an edge with cnt == per_r: spi_clk <= cfg_cpol, spi_trail <= 1, cnt <= 1; at this edge, if en == 0, the FSM SHALL go to IDLE and spi_clk_idle SHALL be set to 1 on the same edge.
REQ-024 In RUN, on all other edges: cnt <= cnt+1 and all pulses = 0.
REQ-025 The active phase SHALL last P-H cycles and the idle-level phase H cycles; for odd P the active phase is longer.
REQ-026 en SHALL be acted on only at a trailing edge; deasserting en mid-period SHALL always complete the current lead+trail pair, so SCK is never truncated.
REQ-027 cfg_cpha = 0: spi_launch = spi_trail and the sample source = spi_lead; spi_start serves as the first launch.
REQ-028 cfg_cpha = 1: spi_launch = spi_lead and the sample source = spi_trail.
REQ-029 spi_sample SHALL equal the sample source delayed by cfg_smpl_dly clk cycles through a (2^DLYW)-1 deep shift register; with delay 0 it coincides with the source.
REQ-030 cfg_cpol and cfg_cpha SHALL be changed only in IDLE; changing them in RUN is unsupported and need not be checked.
REQ-031 spi_lead and spi_trail SHALL never be asserted in the same cycle.

Reset
REQ-032 On rstn = 0, asynchronously: FSM = IDLE, cnt = 1, per_r = 2, spi_clk = 0, spi_clk_idle = 1, all pulses = 0, delay line cleared.
REQ-033 Assertion of rstn mid-operation SHALL abort immediately, with no completion of the current period.
REQ-034 After rstn deasserts, spi_clk SHALL follow cfg_cpol from the first clk edge.

Verification
REQ-035 Scenario: cpol=0, cpha=0, P=4, en held 3 periods -> spi_clk is 2 low / 2 high; 3 lead and 3 trail pulses; sample on lead, launch on trail; first lead 2 cycles after spi_start.
REQ-036 Scenario: cpol=1, cpha=1, P=2 -> spi_clk toggles every cycle with idle level 1; launch on lead, sample on trail.
REQ-037 Scenario: P=5 -> idle-level phase 2 cycles, active phase 3 cycles; P=0 and P=1 both behave as P=2.
REQ-038 Scenario: period changed 4->6 mid-period -> the current period completes at 4; the next period is 6; no short pulse.
REQ-039 Scenario: en dropped one cycle after the leading edge -> the trailing edge still occurs; spi_clk returns to cpol and spi_clk_idle = 1 on that same edge.
REQ-040 Scenario: cfg_smpl_dly = 2 -> spi_sample lags the sample source by exactly 2 cycles; rstn pulsed during RUN -> spi_clk = 0, spi_clk_idle = 1 immediately, and the delay line is flushed.
